md_unit: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers, sitting in the E stage of the five-stage pipeline beside the ALU.
- Accepts signed and unsigned MULT and DIV, plus MTHI and MTLO.
- Models a configurable multi-cycle latency and reports busy so that stall control can hold MFHI, MFLO and new MD instructions in D.
- Written for WIDTH-bit datapaths; the core configures it at 32.

---
 rtl/md_unit_pkg.sv | 17 +
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit_calc.sv | 57 +++++
 rtl/md_unit.sv | 92 +++++++++
 tb/tb_md_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared operation codes and helpers for the multiply/divide unit.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_en;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, a, b, wr_en,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, wr_en,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/md_unit_calc.sv
// Combinational MULT/MULTU/DIV/DIVU result generator; divide by zero returns the current HI/LO.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] cur_hi_i,
  input  logic [WIDTH-1:0] cur_lo_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   safe_b, abs_a, abs_b, uq, ur, sq_mag, sr_mag;
  logic               a_neg, b_neg;

  assign a_neg  = a_i[WIDTH-1];
  assign b_neg  = b_i[WIDTH-1];
  assign safe_b = (b_i == '0) ? WIDTH'(1) : b_i;
  assign abs_a  = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign abs_b  = b_neg ? (~b_i + WIDTH'(1)) : safe_b;

  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
  assign prod_s = {{WIDTH{a_neg}}, a_i} * {{WIDTH{b_neg}}, b_i};

  // Signed divide works on magnitudes so most-negative / -1 wraps cleanly to most-negative.
  assign uq     = a_i / safe_b;
  assign ur     = a_i % safe_b;
  assign sq_mag = abs_a / abs_b;
  assign sr_mag = abs_a % abs_b;

  always_comb begin
    res_hi_o = cur_hi_i;
    res_lo_o = cur_lo_i;
    unique case (op_i)
      MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
      MD_DIV: begin
        if (b_i != '0) begin
          res_lo_o = (a_neg ^ b_neg) ? (~sq_mag + WIDTH'(1)) : sq_mag;
          res_hi_o = a_neg ? (~sr_mag + WIDTH'(1)) : sr_mag;
        end
      end
      MD_DIVU: begin
        if (b_i != '0) begin
          res_lo_o = uq;
          res_hi_o = ur;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; results are computed at launch and
// committed after a fixed latency while busy holds the pipeline.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk_i,
  input  logic  rst_i,
  md_unit_if.slave bus
);

  localparam int unsigned MaxCycles = max_u(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             launch, wr;

  md_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .op_i     (bus.md_op),
    .cur_hi_i (hi_q),
    .cur_lo_i (lo_q),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  assign launch = bus.start && !busy_q && (bus.md_op <= MD_DIVU);
  // A concurrent start always suppresses an MTHI/MTLO write.
  assign wr     = bus.wr_en && !bus.start && !busy_q;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (launch) begin
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      busy_d    = 1'b1;
      cnt_d     = (bus.md_op inside {MD_MULT, MD_MULTU}) ? CntW'(MULT_CYCLES)
                                                         : CntW'(DIV_CYCLES);
    end else if (busy_q) begin
      if (cnt_q <= CntW'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else if (wr) begin
      if (bus.md_op == MD_MTHI) hi_d = bus.a;
      if (bus.md_op == MD_MTLO) lo_d = bus.a;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.stall_req = bus.start | busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default latencies on one instance, minimum latency on another.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  md_unit_if #(.WIDTH(32)) bus  ();
  md_unit_if #(.WIDTH(32)) bus2 ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_min (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (!sel) begin
      bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
    end else begin
      bus2.start = 1'b1; bus2.md_op = op; bus2.a = a; bus2.b = b;
    end
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
  endtask

  // Counts busy cycles (bounded) and records whether hi/lo moved while busy.
  task automatic wait_idle(input bit sel, input logic [31:0] old_hi, input logic [31:0] old_lo,
                           output int n, output bit moved);
    n = 0;
    moved = 1'b0;
    while ((sel ? bus2.busy : bus.busy) && n < 50) begin
      if ((sel ? bus2.hi : bus.hi) !== old_hi || (sel ? bus2.lo : bus.lo) !== old_lo)
        moved = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      bad++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL reset_busy got %b/%b want 0/0", bus.busy, bus.stall_req);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int n; bit moved;
    bus.start = 1'b1; bus.md_op = MD_MULT; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
    #1;
    total++;
    if (bus.stall_req !== 1'b1) begin
      bad++; $display("FAIL mult_stall_req got %b want 1", bus.stall_req);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(1'b0, 32'h0, 32'h0, n, moved);
    total++;
    if (n !== 5) begin bad++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    total++;
    if (moved !== 1'b0) begin bad++; $display("FAIL mult_hold got 1 want 0"); end
    total++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
      bad++; $display("FAIL mult_result got %h/%h want ffffffff/fffffffa", bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu();
    int n; bit moved;
    issue(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, n, moved);
    total++;
    if (n !== 5 || moved !== 1'b0) begin
      bad++; $display("FAIL multu_timing got n=%0d moved=%b want 5/0", n, moved);
    end
    total++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      bad++; $display("FAIL multu_result got %h/%h want fffffffe/00000001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int n; bit moved;
    issue(1'b0, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(1'b0, 32'hFFFF_FFFE, 32'h0000_0001, n, moved);
    total++;
    if (n !== 10 || moved !== 1'b0) begin
      bad++; $display("FAIL div_timing got n=%0d moved=%b want 10/0", n, moved);
    end
    total++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div_result got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo);
    end
    issue(1'b0, MD_DIVU, 32'd7, 32'd0);
    wait_idle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, n, moved);
    total++;
    if (n !== 10) begin bad++; $display("FAIL divzero_busy_cycles got %0d want 10", n); end
    total++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL divzero_hold got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo);
    end
  endtask

  task automatic test_overflow();
    int n; bit moved;
    issue(1'b0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, n, moved);
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
      bad++; $display("FAIL div_overflow got %h/%h want 00000000/80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_mthi();
    bus.wr_en = 1'b1; bus.md_op = MD_MTHI; bus.a = 32'h1234_5678;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    total++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h8000_0000) begin
      bad++; $display("FAIL mthi got %h/%h want 12345678/80000000", bus.hi, bus.lo);
    end
    bus.wr_en = 1'b1; bus.md_op = MD_MTLO; bus.a = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    total++;
    if (bus.lo !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL mtlo got %h want 0badf00d", bus.lo);
    end
  endtask

  task automatic test_busy_ignore();
    int n; bit moved;
    issue(1'b0, MD_MULTU, 32'd2, 32'd3);
    bus.wr_en = 1'b1; bus.md_op = MD_MTLO; bus.a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(1'b0, 32'h1234_5678, 32'h0BAD_F00D, n, moved);
    total++;
    if (n + 2 !== 5 || moved !== 1'b0) begin
      bad++; $display("FAIL busy_ignore_timing got n=%0d moved=%b want 5/0", n + 2, moved);
    end
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd6) begin
      bad++; $display("FAIL busy_ignore_result got %h/%h want 00000000/00000006", bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore_no_relaunch got %b want 0", bus.busy);
    end
  endtask

  task automatic test_wr_start();
    int n; bit moved;
    bus.wr_en = 1'b1;
    issue(1'b0, MD_MULT, 32'd3, 32'd3);
    bus.wr_en = 1'b0;
    wait_idle(1'b0, 32'h0, 32'd6, n, moved);
    total++;
    if (n !== 5 || moved !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd9) begin
      bad++; $display("FAIL wr_start got n=%0d hi=%h lo=%h want 5/00000000/00000009",
                      n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_unknown();
    issue(1'b0, MD_MFHI, 32'd1, 32'd1);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL unknown_start got %b want 0", bus.busy); end
    bus.wr_en = 1'b1; bus.md_op = MD_MFLO; bus.a = 32'hFFFF_0000;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd9) begin
      bad++; $display("FAIL unknown_write got %h/%h want 00000000/00000009", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit moved;
    issue(1'b0, MD_DIV, 32'd50, 32'd3);
    repeat (2) begin @(posedge clk); #1; end
    bus.wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b want 0/0/0", bus.hi, bus.lo, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, MD_MULT, 32'd4, 32'd5);
    wait_idle(1'b0, 32'h0, 32'h0, n, moved);
    total++;
    if (n !== 5 || bus.hi !== 32'h0 || bus.lo !== 32'd20) begin
      bad++; $display("FAIL reset_mid_mult got n=%0d hi=%h lo=%h want 5/0/20", n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_min_latency();
    int n; bit moved;
    issue(1'b1, MD_MULT, 32'd4, 32'd5);
    wait_idle(1'b1, 32'h0, 32'h0, n, moved);
    total++;
    if (n !== 1 || moved !== 1'b0 || bus2.hi !== 32'h0 || bus2.lo !== 32'd20) begin
      bad++; $display("FAIL min_mult got n=%0d hi=%h lo=%h want 1/0/20", n, bus2.hi, bus2.lo);
    end
    issue(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(1'b1, 32'h0, 32'd20, n, moved);
    total++;
    if (n !== 1 || bus2.hi !== 32'hFFFF_FFFF || bus2.lo !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL min_div got n=%0d hi=%h lo=%h want 1/ffffffff/fffffffd",
                      n, bus2.hi, bus2.lo);
    end
    issue(1'b1, MD_DIVU, 32'd100, 32'd7);
    wait_idle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, n, moved);
    total++;
    if (n !== 1 || bus2.hi !== 32'd2 || bus2.lo !== 32'd14) begin
      bad++; $display("FAIL min_back_to_back got n=%0d hi=%h lo=%h want 1/2/14",
                      n, bus2.hi, bus2.lo);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.md_op = 3'd0;  bus.a = '0;  bus.b = '0;  bus.wr_en = 1'b0;
    bus2.start = 1'b0; bus2.md_op = 3'd0; bus2.a = '0; bus2.b = '0; bus2.wr_en = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_overflow();
    test_mthi();
    test_busy_ignore();
    test_wr_start();
    test_unknown();
    test_reset_mid();
    test_min_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
